// File: rtl/mrv1_pkg.sv
// Shared types and sizing for the mrv1 issue path.
// Slot field widths come from the localparams below; top-level parameters default to them.
package mrv1_pkg;

   localparam int MRV1_NUM_THREADS = 8;
   localparam int MRV1_NUM_FU      = 5;
   localparam int MRV1_PAYLOAD_W   = 128;
   localparam int MRV1_RF_ADDR_W   = 5;

   function automatic int mrv1_tid_width(input int num_threads);
      return (num_threads > 1) ? $clog2(num_threads) : 1;
   endfunction

   localparam int MRV1_TID_WIDTH = mrv1_tid_width(MRV1_NUM_THREADS);

   typedef struct packed {
      logic [MRV1_NUM_FU-1:0]    fu_req;
      logic [MRV1_PAYLOAD_W-1:0] payload;
      logic                      rs0_vld;
      logic [MRV1_RF_ADDR_W-1:0] rs0_addr;
      logic                      rs1_vld;
      logic [MRV1_RF_ADDR_W-1:0] rs1_addr;
      logic                      rd_vld;
      logic [MRV1_RF_ADDR_W-1:0] rd_addr;
   } mrv1_iss_slot_t;

   typedef logic [MRV1_NUM_THREADS-1:0][31:0] mrv1_sb_t;

endpackage

// File: rtl/mrv1_rr_arbiter.sv
// Round-robin arbiter: double-width masked priority encoder starting at ptr_i.
// Lower half holds requests at or above ptr_i, upper half the full vector for wrap-around.
module mrv1_rr_arbiter #(
   parameter  int NUM_REQ_P = 8,
   localparam int IDX_W     = (NUM_REQ_P > 1) ? $clog2(NUM_REQ_P) : 1
) (
   input  logic [NUM_REQ_P-1:0] req_i,
   input  logic [IDX_W-1:0]     ptr_i,
   output logic [NUM_REQ_P-1:0] grant_o,
   output logic [IDX_W-1:0]     grant_idx_o,
   output logic                 any_o
);

   logic [NUM_REQ_P-1:0]   mask;
   logic [2*NUM_REQ_P-1:0] dbl_req;

   always_comb begin
      for (int i = 0; i < NUM_REQ_P; i++) begin
         mask[i] = (i >= int'(ptr_i));
      end
   end

   assign dbl_req = {req_i, req_i & mask};

   // Scan from the top down so the lowest set bit is the one that sticks.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      for (int i = 2*NUM_REQ_P-1; i >= 0; i--) begin
         if (dbl_req[i]) begin
            any_o       = 1'b1;
            grant_idx_o = IDX_W'(i % NUM_REQ_P);
         end
      end
      if (any_o) grant_o[grant_idx_o] = 1'b1;
   end

endmodule

// File: rtl/mrv1_issue_sched.sv
// Per-thread issue scheduler: one decoded slot per thread, per-thread register scoreboard,
// round-robin pick of one hazard-free thread per cycle onto the shared issue port.
module mrv1_issue_sched
   import mrv1_pkg::*;
#(
   parameter  int NUM_THREADS_P   = MRV1_NUM_THREADS,
   parameter  int NUM_FU_P        = MRV1_NUM_FU,
   parameter  int PAYLOAD_WIDTH_P = MRV1_PAYLOAD_W,
   parameter  int rf_addr_width_p = MRV1_RF_ADDR_W,
   localparam int TID_W           = mrv1_tid_width(NUM_THREADS_P)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   // Decoder handshake: an instruction is taken at the edge where dec_vld_i & dec_rdy_o;
   // dec_rdy_o depends only on dec_tid_i and registered state, never on dec_vld_i.
   input  logic                       dec_vld_i,
   output logic                       dec_rdy_o,
   input  logic [TID_W-1:0]           dec_tid_i,
   input  logic [NUM_FU_P-1:0]        dec_fu_req_i,
   input  logic [PAYLOAD_WIDTH_P-1:0] dec_payload_i,
   input  logic                       dec_rs0_vld_i,
   input  logic [rf_addr_width_p-1:0] dec_rs0_addr_i,
   input  logic                       dec_rs1_vld_i,
   input  logic [rf_addr_width_p-1:0] dec_rs1_addr_i,
   input  logic                       dec_rd_vld_i,
   input  logic [rf_addr_width_p-1:0] dec_rd_addr_i,
   input  logic [NUM_FU_P-1:0]        fu_rdy_i,
   output logic                       iss_vld_o,
   output logic [TID_W-1:0]           iss_tid_o,
   output logic [NUM_FU_P-1:0]        iss_fu_req_o,
   output logic [PAYLOAD_WIDTH_P-1:0] iss_payload_o,
   output logic [rf_addr_width_p-1:0] iss_rs0_addr_o,
   output logic [rf_addr_width_p-1:0] iss_rs1_addr_o,
   output logic                       iss_rd_vld_o,
   output logic [rf_addr_width_p-1:0] iss_rd_addr_o,
   input  logic                       wb_vld_i,
   input  logic [TID_W-1:0]           wb_tid_i,
   input  logic [rf_addr_width_p-1:0] wb_rd_addr_i,
   input  logic                       flush_i,
   input  logic [TID_W-1:0]           flush_tid_i
);

   localparam int SB_W = 1 << rf_addr_width_p;

   mrv1_iss_slot_t                        slot_q [NUM_THREADS_P];
   mrv1_iss_slot_t                        dec_slot;
   logic [NUM_THREADS_P-1:0]              slot_vld_q, slot_vld_d;
   logic [NUM_THREADS_P-1:0][SB_W-1:0]    sb_q, sb_d;
   logic [TID_W-1:0]                      rr_ptr_q, rr_ptr_d;

   logic [NUM_THREADS_P-1:0] raw_hz, waw_hz, fu_ok, flush_hit, thr_rdy;
   logic [NUM_THREADS_P-1:0] grant_oh;
   logic [TID_W-1:0]         grant_idx;
   logic                     grant_any;
   logic                     enq;

   assign dec_rdy_o = ~slot_vld_q[dec_tid_i];
   assign enq       = dec_vld_i & dec_rdy_o & ~(flush_i & (flush_tid_i == dec_tid_i));

   always_comb begin
      dec_slot          = '0;
      dec_slot.fu_req   = dec_fu_req_i;
      dec_slot.payload  = dec_payload_i;
      dec_slot.rs0_vld  = dec_rs0_vld_i;
      dec_slot.rs0_addr = dec_rs0_addr_i;
      dec_slot.rs1_vld  = dec_rs1_vld_i;
      dec_slot.rs1_addr = dec_rs1_addr_i;
      dec_slot.rd_vld   = dec_rd_vld_i;
      dec_slot.rd_addr  = dec_rd_addr_i;
   end

   // x0 never enters the scoreboard, so an x0 operand can never stall.
   always_comb begin
      for (int t = 0; t < NUM_THREADS_P; t++) begin
         raw_hz[t]    = (slot_q[t].rs0_vld && (slot_q[t].rs0_addr != '0) && sb_q[t][slot_q[t].rs0_addr])
                     || (slot_q[t].rs1_vld && (slot_q[t].rs1_addr != '0) && sb_q[t][slot_q[t].rs1_addr]);
         waw_hz[t]    = slot_q[t].rd_vld && (slot_q[t].rd_addr != '0) && sb_q[t][slot_q[t].rd_addr];
         fu_ok[t]     = |(slot_q[t].fu_req & fu_rdy_i);
         flush_hit[t] = flush_i && (flush_tid_i == TID_W'(t));
         thr_rdy[t]   = slot_vld_q[t] & ~raw_hz[t] & ~waw_hz[t] & fu_ok[t] & ~flush_hit[t];
      end
   end

   mrv1_rr_arbiter #(
      .NUM_REQ_P (NUM_THREADS_P)
   ) u_arb (
      .req_i       (thr_rdy),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant_oh),
      .grant_idx_o (grant_idx),
      .any_o       (grant_any)
   );

   assign iss_vld_o      = grant_any;
   assign iss_tid_o      = grant_idx;
   assign iss_fu_req_o   = grant_any ? slot_q[grant_idx].fu_req : '0;
   assign iss_payload_o  = slot_q[grant_idx].payload;
   assign iss_rs0_addr_o = slot_q[grant_idx].rs0_addr;
   assign iss_rs1_addr_o = slot_q[grant_idx].rs1_addr;
   assign iss_rd_vld_o   = grant_any & slot_q[grant_idx].rd_vld;
   assign iss_rd_addr_o  = slot_q[grant_idx].rd_addr;

   // Enqueue only targets a free slot, so it never collides with the issue clear.
   always_comb begin
      slot_vld_d = slot_vld_q & ~grant_oh;
      if (flush_i) slot_vld_d[flush_tid_i] = 1'b0;
      if (enq)     slot_vld_d[dec_tid_i]   = 1'b1;
   end

   // Issue set is applied after writeback clear, so set wins on a collision.
   always_comb begin
      sb_d = sb_q;
      if (wb_vld_i && (wb_rd_addr_i != '0)) sb_d[wb_tid_i][wb_rd_addr_i] = 1'b0;
      if (grant_any && slot_q[grant_idx].rd_vld && (slot_q[grant_idx].rd_addr != '0))
         sb_d[grant_idx][slot_q[grant_idx].rd_addr] = 1'b1;
   end

   assign rr_ptr_d = grant_any ? grant_idx + TID_W'(1) : rr_ptr_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         slot_vld_q <= '0;
         sb_q       <= '0;
         rr_ptr_q   <= '0;
      end else begin
         slot_vld_q <= slot_vld_d;
         sb_q       <= sb_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) slot_q[dec_tid_i] <= dec_slot;
   end

   a_iss_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      iss_vld_o |-> $onehot(iss_fu_req_o));

   a_wb_pending: assert property (@(posedge clk_i) disable iff (rst_i)
      (wb_vld_i && (wb_rd_addr_i != '0)) |-> sb_q[wb_tid_i][wb_rd_addr_i]);

   a_enq_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
      enq |-> $onehot(dec_fu_req_i));

   a_no_set_clear: assert property (@(posedge clk_i) disable iff (rst_i)
      !(grant_any && slot_q[grant_idx].rd_vld && (slot_q[grant_idx].rd_addr != '0)
        && wb_vld_i && (wb_tid_i == grant_idx) && (wb_rd_addr_i == slot_q[grant_idx].rd_addr)));

endmodule

// File: tb/tb_mrv1_issue_sched.sv
// Directed bench for mrv1_issue_sched: thread-level model checked every cycle plus literal pins.
module tb_mrv1_issue_sched;

   localparam int NT = 8;
   localparam logic [4:0] FU_INT = 5'b00001;
   localparam logic [4:0] FU_MUL = 5'b00010;

   logic         clk;
   logic         rst_i;
   logic         dec_vld_i, dec_rdy_o;
   logic [2:0]   dec_tid_i;
   logic [4:0]   dec_fu_req_i;
   logic [127:0] dec_payload_i;
   logic         dec_rs0_vld_i, dec_rs1_vld_i, dec_rd_vld_i;
   logic [4:0]   dec_rs0_addr_i, dec_rs1_addr_i, dec_rd_addr_i;
   logic [4:0]   fu_rdy_i;
   logic         iss_vld_o, iss_rd_vld_o;
   logic [2:0]   iss_tid_o;
   logic [4:0]   iss_fu_req_o;
   logic [127:0] iss_payload_o;
   logic [4:0]   iss_rs0_addr_o, iss_rs1_addr_o, iss_rd_addr_o;
   logic         wb_vld_i;
   logic [2:0]   wb_tid_i;
   logic [4:0]   wb_rd_addr_i;
   logic         flush_i;
   logic [2:0]   flush_tid_i;

   int n_checks = 0;
   int n_errors = 0;

   mrv1_issue_sched dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .dec_vld_i      (dec_vld_i),
      .dec_rdy_o      (dec_rdy_o),
      .dec_tid_i      (dec_tid_i),
      .dec_fu_req_i   (dec_fu_req_i),
      .dec_payload_i  (dec_payload_i),
      .dec_rs0_vld_i  (dec_rs0_vld_i),
      .dec_rs0_addr_i (dec_rs0_addr_i),
      .dec_rs1_vld_i  (dec_rs1_vld_i),
      .dec_rs1_addr_i (dec_rs1_addr_i),
      .dec_rd_vld_i   (dec_rd_vld_i),
      .dec_rd_addr_i  (dec_rd_addr_i),
      .fu_rdy_i       (fu_rdy_i),
      .iss_vld_o      (iss_vld_o),
      .iss_tid_o      (iss_tid_o),
      .iss_fu_req_o   (iss_fu_req_o),
      .iss_payload_o  (iss_payload_o),
      .iss_rs0_addr_o (iss_rs0_addr_o),
      .iss_rs1_addr_o (iss_rs1_addr_o),
      .iss_rd_vld_o   (iss_rd_vld_o),
      .iss_rd_addr_o  (iss_rd_addr_o),
      .wb_vld_i       (wb_vld_i),
      .wb_tid_i       (wb_tid_i),
      .wb_rd_addr_i   (wb_rd_addr_i),
      .flush_i        (flush_i),
      .flush_tid_i    (flush_tid_i)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // thread-level model: per-thread pending instruction and busy-register sets
   bit           m_known = 0;
   bit           m_vld  [NT];
   logic [4:0]   m_fu   [NT];
   logic [127:0] m_pl   [NT];
   bit           m_rs0v [NT], m_rs1v [NT], m_rdv [NT];
   logic [4:0]   m_rs0  [NT], m_rs1 [NT], m_rd [NT];
   bit           m_sb   [NT][32];
   int           m_rr;

   function automatic bit busy(input int t, input bit v, input logic [4:0] r);
      return v && (r != 0) && m_sb[t][r];
   endfunction

   function automatic bit thread_ready(input int t);
      return m_vld[t] && !busy(t, m_rs0v[t], m_rs0[t]) && !busy(t, m_rs1v[t], m_rs1[t])
             && !busy(t, m_rdv[t], m_rd[t]) && ((m_fu[t] & fu_rdy_i) != 0)
             && !(flush_i && (int'(flush_tid_i) == t));
   endfunction

   // compare process: check this cycle's outputs, then advance the model past the edge
   bit found;
   int g, tt;
   bit enq;
   always @(negedge clk) begin
      found = 0;
      g = 0;
      if (m_known) begin
         for (int k = 0; k < NT; k++) begin
            tt = (m_rr + k) % NT;
            if (!found && thread_ready(tt)) begin
               found = 1;
               g = tt;
            end
         end
         chk("m_iss_vld", iss_vld_o, found);
         chk("m_iss_fu_req", iss_fu_req_o, found ? m_fu[g] : 5'b0);
         chk("m_dec_rdy", dec_rdy_o, !m_vld[dec_tid_i]);
         if (found) begin
            chk("m_iss_tid", iss_tid_o, g);
            chk("m_iss_payload", iss_payload_o, m_pl[g]);
            chk("m_iss_rs0", iss_rs0_addr_o, m_rs0[g]);
            chk("m_iss_rs1", iss_rs1_addr_o, m_rs1[g]);
            chk("m_iss_rd_vld", iss_rd_vld_o, m_rdv[g]);
            chk("m_iss_rd", iss_rd_addr_o, m_rd[g]);
         end
      end
      if (rst_i) begin
         for (int t = 0; t < NT; t++) begin
            m_vld[t] = 0;
            for (int r = 0; r < 32; r++) m_sb[t][r] = 0;
         end
         m_rr = 0;
         m_known = 1;
      end else if (m_known) begin
         enq = dec_vld_i && !m_vld[dec_tid_i] && !(flush_i && flush_tid_i == dec_tid_i);
         if (wb_vld_i && wb_rd_addr_i != 0) m_sb[wb_tid_i][wb_rd_addr_i] = 0;
         if (found) begin
            m_vld[g] = 0;
            if (m_rdv[g] && m_rd[g] != 0) m_sb[g][m_rd[g]] = 1;
            m_rr = (g + 1) % NT;
         end
         if (flush_i) m_vld[flush_tid_i] = 0;
         if (enq) begin
            m_vld[dec_tid_i]  = 1;
            m_fu[dec_tid_i]   = dec_fu_req_i;
            m_pl[dec_tid_i]   = dec_payload_i;
            m_rs0v[dec_tid_i] = dec_rs0_vld_i;
            m_rs0[dec_tid_i]  = dec_rs0_addr_i;
            m_rs1v[dec_tid_i] = dec_rs1_vld_i;
            m_rs1[dec_tid_i]  = dec_rs1_addr_i;
            m_rdv[dec_tid_i]  = dec_rd_vld_i;
            m_rd[dec_tid_i]   = dec_rd_addr_i;
         end
      end
   end

   // driver tasks
   task automatic drive_idle();
      rst_i     = 1'b0;
      dec_vld_i = 1'b0;
      wb_vld_i  = 1'b0;
      flush_i   = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      drive_idle();
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_enq(input int tid, input logic [4:0] fu,
                            input logic rs0v, input logic [4:0] rs0,
                            input logic rs1v, input logic [4:0] rs1,
                            input logic rdv, input logic [4:0] rd);
      dec_vld_i      = 1'b1;
      dec_tid_i      = 3'(tid);
      dec_fu_req_i   = fu;
      dec_payload_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      dec_rs0_vld_i  = rs0v;
      dec_rs0_addr_i = rs0;
      dec_rs1_vld_i  = rs1v;
      dec_rs1_addr_i = rs1;
      dec_rd_vld_i   = rdv;
      dec_rd_addr_i  = rd;
   endtask

   task automatic drive_wb(input int tid, input logic [4:0] rd);
      wb_vld_i     = 1'b1;
      wb_tid_i     = 3'(tid);
      wb_rd_addr_i = rd;
   endtask

   task automatic expect_iss(input string nm, input logic vld, input int tid);
      chk({nm, "_vld"}, iss_vld_o, vld);
      if (vld) chk({nm, "_tid"}, iss_tid_o, tid);
   endtask

   initial begin
      drive_idle();
      rst_i = 1'b1;
      dec_tid_i = '0; dec_fu_req_i = '0; dec_payload_i = '0;
      dec_rs0_vld_i = 0; dec_rs1_vld_i = 0; dec_rd_vld_i = 0;
      dec_rs0_addr_i = '0; dec_rs1_addr_i = '0; dec_rd_addr_i = '0;
      wb_tid_i = '0; wb_rd_addr_i = '0; flush_tid_i = '0;
      fu_rdy_i = '1;
      repeat (2) @(posedge clk);
      #1;
      drive_idle();

      // reset state
      sample();
      chk("rst_iss_vld", iss_vld_o, 0);
      chk("rst_iss_fu_req", iss_fu_req_o, 0);
      chk("rst_dec_rdy", dec_rdy_o, 1);
      next_cycle();

      // T0 ADD x5 <- x1, x2
      drive_enq(0, FU_INT, 1, 5'd1, 1, 5'd2, 1, 5'd5);
      sample(); expect_iss("add_enq_cycle", 0, 0); next_cycle();
      sample();
      expect_iss("add_issue", 1, 0);
      chk("add_fu_req", iss_fu_req_o, FU_INT);
      chk("add_dec_rdy_busy", dec_rdy_o, 0);
      next_cycle();
      sample();
      chk("add_dec_rdy_free", dec_rdy_o, 1);
      chk("model_sb_0_5", m_sb[0][5], 1);
      next_cycle();

      // RAW on x5 until writeback
      drive_enq(0, FU_INT, 1, 5'd5, 0, 5'd0, 1, 5'd6);
      sample(); expect_iss("raw_enq", 0, 0); next_cycle();
      repeat (2) begin
         sample(); expect_iss("raw_stall", 0, 0); next_cycle();
      end
      drive_wb(0, 5'd5);
      sample(); expect_iss("raw_wb_cycle", 0, 0); next_cycle();
      sample(); expect_iss("raw_release", 1, 0); next_cycle();
      drive_wb(0, 5'd6);
      sample(); next_cycle();

      // round-robin over all threads from a fresh pointer
      rst_i = 1'b1;
      sample(); next_cycle();
      fu_rdy_i = '0;
      for (int t = 0; t < NT; t++) begin
         drive_enq(t, FU_INT, 0, 5'd0, 0, 5'd0, 0, 5'd0);
         sample(); next_cycle();
      end
      fu_rdy_i = '1;
      for (int k = 0; k <= NT; k++) begin
         if (k == 1) drive_enq(0, FU_INT, 0, 5'd0, 0, 5'd0, 0, 5'd0);
         sample(); expect_iss("rr_order", 1, k % NT); next_cycle();
      end

      // pointer now 1: T3 granted first, then T5 beats pending T1
      fu_rdy_i = '0;
      drive_enq(1, FU_MUL, 0, 5'd0, 0, 5'd0, 0, 5'd0); sample(); next_cycle();
      drive_enq(3, FU_INT, 0, 5'd0, 0, 5'd0, 0, 5'd0); sample(); next_cycle();
      drive_enq(5, FU_INT, 0, 5'd0, 0, 5'd0, 0, 5'd0); sample(); next_cycle();
      fu_rdy_i = FU_INT;
      sample(); expect_iss("rr_first_3", 1, 3); next_cycle();
      fu_rdy_i = '1;
      sample(); expect_iss("rr_then_5", 1, 5); next_cycle();
      sample(); expect_iss("rr_then_1", 1, 1); next_cycle();

      // FU availability: MUL blocked, INT proceeds
      fu_rdy_i = ~FU_MUL;
      drive_enq(2, FU_MUL, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      sample(); expect_iss("fu_enq_mul", 0, 0); next_cycle();
      drive_enq(3, FU_INT, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      sample(); expect_iss("fu_mul_blocked", 0, 0); next_cycle();
      sample(); expect_iss("fu_int_issue", 1, 3); next_cycle();
      sample(); expect_iss("fu_mul_hold", 0, 0); next_cycle();
      fu_rdy_i = '1;
      sample(); expect_iss("fu_mul_issue", 1, 2); chk("fu_mul_req", iss_fu_req_o, FU_MUL); next_cycle();

      // flush drops a same-cycle enqueue
      drive_enq(4, FU_INT, 0, 5'd0, 0, 5'd0, 1, 5'd7);
      flush_i = 1'b1; flush_tid_i = 3'd4;
      sample(); next_cycle();
      sample(); expect_iss("flush_enq_drop", 0, 0); chk("flush_enq_dec_rdy", dec_rdy_o, 1); next_cycle();

      // flush masks a thread that would be granted; scoreboard untouched
      fu_rdy_i = '0;
      drive_enq(4, FU_INT, 0, 5'd0, 0, 5'd0, 1, 5'd7);
      sample(); next_cycle();
      fu_rdy_i = '1;
      flush_i = 1'b1; flush_tid_i = 3'd4;
      sample(); expect_iss("flush_grant", 0, 0); next_cycle();
      sample(); expect_iss("flush_after", 0, 0); chk("model_sb_4_7", m_sb[4][7], 0); next_cycle();
      drive_enq(4, FU_INT, 1, 5'd7, 0, 5'd0, 0, 5'd0);
      sample(); next_cycle();
      sample(); expect_iss("flush_sb_clean", 1, 4); next_cycle();

      // x0 operands and destination never stall
      drive_enq(1, FU_INT, 1, 5'd0, 1, 5'd0, 1, 5'd0);
      sample(); next_cycle();
      sample(); expect_iss("x0_issue", 1, 1); chk("x0_rd_addr", iss_rd_addr_o, 0); next_cycle();
      drive_enq(1, FU_INT, 1, 5'd0, 0, 5'd0, 1, 5'd0);
      sample(); next_cycle();
      sample(); expect_iss("x0_again", 1, 1); next_cycle();

      // mid-stream reset with slots full and scoreboard set
      drive_enq(5, FU_INT, 0, 5'd0, 0, 5'd0, 1, 5'd10);
      sample(); next_cycle();
      sample(); expect_iss("pre_rst_t5", 1, 5); next_cycle();
      drive_enq(6, FU_INT, 0, 5'd0, 0, 5'd0, 1, 5'd11);
      sample(); next_cycle();
      sample(); expect_iss("pre_rst_t6", 1, 6); next_cycle();
      fu_rdy_i = '0;
      for (int t = 0; t < 3; t++) begin
         drive_enq(t, FU_INT, 0, 5'd0, 0, 5'd0, 1, 5'd12);
         sample(); next_cycle();
      end
      fu_rdy_i = '1;
      rst_i = 1'b1;
      sample(); next_cycle();
      sample();
      expect_iss("post_rst", 0, 0);
      chk("post_rst_dec_rdy", dec_rdy_o, 1);
      chk("model_sb_5_10", m_sb[5][10], 0);
      next_cycle();
      drive_enq(5, FU_INT, 1, 5'd10, 0, 5'd0, 0, 5'd0);
      sample(); next_cycle();
      sample(); expect_iss("post_rst_no_stall", 1, 5); next_cycle();
      repeat (2) next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
